// File: rtl/instruction_fetch.sv
// Instruction fetch: reads opcode plus up to two little-endian operand bytes at the PC
// and presents each complete instruction over a valid/ready handshake.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   pc_count,
    output logic                    pc_increment,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_rd_en,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    flush,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [DATA_WIDTH-1:0]   instr_opcode,
    output logic [2*DATA_WIDTH-1:0] instr_operand,
    output logic [1:0]              instr_length
);

    typedef enum logic [2:0] {
        StOpRd,
        StOpCap,
        StB1Rd,
        StB1Cap,
        StB2Rd,
        StB2Cap,
        StHold
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
    logic [2*DATA_WIDTH-1:0] operand_q, operand_d;
    logic [1:0]              length_q, length_d;
    logic [1:0]              op_length;

    assign mem_addr      = pc_count;
    assign instr_opcode  = opcode_q;
    assign instr_operand = operand_q;
    assign instr_length  = length_q;

    always_comb begin
        unique case (mem_data[7:6])
            2'b00:   op_length = 2'd1;
            2'b01:   op_length = 2'd2;
            default: op_length = 2'd3;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StOpRd;
            opcode_q  <= '0;
            operand_q <= '0;
            length_q  <= 2'd1;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            length_q  <= length_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        operand_d    = operand_q;
        length_d     = length_q;
        mem_rd_en    = 1'b0;
        pc_increment = 1'b0;
        instr_valid  = 1'b0;

        unique case (state_q)
            StOpRd: begin
                mem_rd_en    = 1'b1;
                pc_increment = 1'b1;
                state_d      = StOpCap;
            end
            StOpCap: begin
                opcode_d  = mem_data;
                operand_d = '0;
                length_d  = op_length;
                state_d   = (op_length == 2'd1) ? StHold : StB1Rd;
            end
            StB1Rd: begin
                mem_rd_en    = 1'b1;
                pc_increment = 1'b1;
                state_d      = StB1Cap;
            end
            StB1Cap: begin
                operand_d[DATA_WIDTH-1:0] = mem_data;
                state_d = (length_q == 2'd2) ? StHold : StB2Rd;
            end
            StB2Rd: begin
                mem_rd_en    = 1'b1;
                pc_increment = 1'b1;
                state_d      = StB2Cap;
            end
            StB2Cap: begin
                operand_d[2*DATA_WIDTH-1:DATA_WIDTH] = mem_data;
                state_d = StHold;
            end
            StHold: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_d = StOpRd;
                end
            end
            default: state_d = StOpRd;
        endcase

        // Jump: drop the partial fetch and keep the PC quiet while execute loads it.
        if (flush) begin
            state_d      = StOpRd;
            opcode_d     = opcode_q;
            operand_d    = operand_q;
            length_d     = length_q;
            mem_rd_en    = 1'b0;
            pc_increment = 1'b0;
        end

        if (!reset) begin
            mem_rd_en    = 1'b0;
            pc_increment = 1'b0;
            instr_valid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural PC and 1-cycle-latency memory.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] pc_count;
    logic        pc_increment;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_data;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [1:0]  instr_length;

    logic        pc_set;
    logic [15:0] pc_set_value;
    logic [7:0]  mem [0:65535];
    int          incr_cnt;
    int          errors = 0;
    int          checks = 0;

    instruction_fetch #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_count      (pc_count),
        .pc_increment  (pc_increment),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_data      (mem_data),
        .flush         (flush),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_length  (instr_length)
    );

    always #5 clock = ~clock;

    // Program counter and instruction memory environment.
    always @(posedge clock) begin
        if (!reset) pc_count <= 16'h0000;
        else if (pc_set) pc_count <= pc_set_value;
        else if (pc_increment) pc_count <= pc_count + 16'd1;

        if (mem_rd_en) mem_data <= mem[mem_addr];

        if (!reset) incr_cnt <= 0;
        else if (pc_increment) incr_cnt <= incr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    // Leaves the DUT in its first OP_RD cycle (cycle 0) with reset released.
    task automatic do_reset();
        reset  = 1'b0;
        flush  = 1'b0;
        pc_set = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        flush        = 1'b0;
        pc_set       = 1'b0;
        pc_set_value = 16'h0000;
        instr_ready  = 1'b1;
        mem_data     = 8'h00;
        clear_mem();

        // Reset state
        step();
        step();
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_opcode", 32'(instr_opcode), 0);
        check("rst_operand", 32'(instr_operand), 0);
        check("rst_length", 32'(instr_length), 1);
        check("rst_rd", 32'(mem_rd_en), 0);
        check("rst_incr", 32'(pc_increment), 0);

        // 1-byte instruction
        mem[0] = 8'h05;
        do_reset();
        check("t1_rd", 32'(mem_rd_en), 1);
        check("t1_incr", 32'(pc_increment), 1);
        check("t1_addr", 32'(mem_addr), 32'h0000);
        check("t1_nvalid0", 32'(instr_valid), 0);
        step();
        check("t1_nvalid1", 32'(instr_valid), 0);
        check("t1_cap_rd", 32'(mem_rd_en), 0);
        step();
        check("t1_valid", 32'(instr_valid), 1);
        check("t1_opcode", 32'(instr_opcode), 32'h05);
        check("t1_operand", 32'(instr_operand), 32'h0000);
        check("t1_length", 32'(instr_length), 1);
        check("t1_incr_cnt", 32'(incr_cnt), 1);
        step();
        check("t1_next_valid", 32'(instr_valid), 0);
        check("t1_next_addr", 32'(mem_addr), 32'h0001);
        check("t1_next_rd", 32'(mem_rd_en), 1);

        // 3-byte instruction
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h34; mem[2] = 8'h12;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            check("t2_nvalid", 32'(instr_valid), 0);
            step();
        end
        check("t2_valid", 32'(instr_valid), 1);
        check("t2_opcode", 32'(instr_opcode), 32'h80);
        check("t2_operand", 32'(instr_operand), 32'h1234);
        check("t2_length", 32'(instr_length), 3);
        check("t2_incr_cnt", 32'(incr_cnt), 3);

        // 2-byte instruction held by backpressure
        clear_mem();
        mem[0] = 8'h41; mem[1] = 8'hAA;
        instr_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) step();
        for (int c = 0; c < 5; c++) begin
            check("t3_hold_valid", 32'(instr_valid), 1);
            check("t3_hold_rd", 32'(mem_rd_en), 0);
            check("t3_hold_incr", 32'(pc_increment), 0);
            step();
        end
        check("t3_opcode", 32'(instr_opcode), 32'h41);
        check("t3_operand", 32'(instr_operand), 32'h00AA);
        check("t3_length", 32'(instr_length), 2);
        check("t3_incr_cnt", 32'(incr_cnt), 2);
        instr_ready = 1'b1;
        step();
        check("t3_drop_valid", 32'(instr_valid), 0);
        check("t3_next_rd", 32'(mem_rd_en), 1);
        check("t3_next_addr", 32'(mem_addr), 32'h0002);

        // Flush in B1_CAP of a 3-byte instruction
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h34; mem[2] = 8'h12; mem[16'h0100] = 8'h05;
        do_reset();
        for (int c = 0; c < 3; c++) step();
        flush = 1'b1; pc_set = 1'b1; pc_set_value = 16'h0100;
        #1;
        check("t4_flush_incr", 32'(pc_increment), 0);
        check("t4_flush_rd", 32'(mem_rd_en), 0);
        step();
        flush = 1'b0; pc_set = 1'b0;
        #1;
        check("t4_addr", 32'(mem_addr), 32'h0100);
        check("t4_rd", 32'(mem_rd_en), 1);
        check("t4_nvalid0", 32'(instr_valid), 0);
        step();
        check("t4_nvalid1", 32'(instr_valid), 0);
        step();
        check("t4_valid", 32'(instr_valid), 1);
        check("t4_opcode", 32'(instr_opcode), 32'h05);
        check("t4_length", 32'(instr_length), 1);
        check("t4_operand", 32'(instr_operand), 32'h0000);

        // Flush in B2_RD: read and increment must be suppressed
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h34; mem[16'h0200] = 8'h41; mem[16'h0201] = 8'h77;
        do_reset();
        for (int c = 0; c < 4; c++) step();
        check("t5_pre_rd", 32'(mem_rd_en), 1);
        flush = 1'b1; pc_set = 1'b1; pc_set_value = 16'h0200;
        #1;
        check("t5_flush_rd", 32'(mem_rd_en), 0);
        check("t5_flush_incr", 32'(pc_increment), 0);
        step();
        flush = 1'b0; pc_set = 1'b0;
        #1;
        check("t5_addr", 32'(mem_addr), 32'h0200);
        for (int c = 0; c < 4; c++) step();
        check("t5_valid", 32'(instr_valid), 1);
        check("t5_opcode", 32'(instr_opcode), 32'h41);
        check("t5_operand", 32'(instr_operand), 32'h0077);
        check("t5_length", 32'(instr_length), 2);

        // 3-byte instruction straddling the PC wrap
        clear_mem();
        mem[16'hFFFF] = 8'hC3; mem[0] = 8'hCD; mem[1] = 8'hAB;
        do_reset();
        flush = 1'b1; pc_set = 1'b1; pc_set_value = 16'hFFFF;
        step();
        flush = 1'b0; pc_set = 1'b0;
        #1;
        check("t6_addr0", 32'(mem_addr), 32'hFFFF);
        check("t6_rd0", 32'(mem_rd_en), 1);
        step(); step();
        check("t6_addr1", 32'(mem_addr), 32'h0000);
        check("t6_rd1", 32'(mem_rd_en), 1);
        step(); step();
        check("t6_addr2", 32'(mem_addr), 32'h0001);
        check("t6_rd2", 32'(mem_rd_en), 1);
        step(); step();
        check("t6_valid", 32'(instr_valid), 1);
        check("t6_opcode", 32'(instr_opcode), 32'hC3);
        check("t6_operand", 32'(instr_operand), 32'hABCD);
        check("t6_length", 32'(instr_length), 3);

        // Reset during B2_RD
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h34; mem[2] = 8'h12;
        do_reset();
        for (int c = 0; c < 4; c++) step();
        check("t7_pre_rd", 32'(mem_rd_en), 1);
        reset = 1'b0;
        #1;
        check("t7_rst_rd", 32'(mem_rd_en), 0);
        check("t7_rst_incr", 32'(pc_increment), 0);
        step();
        check("t7_valid", 32'(instr_valid), 0);
        check("t7_opcode", 32'(instr_opcode), 0);
        check("t7_operand", 32'(instr_operand), 0);
        check("t7_length", 32'(instr_length), 1);
        reset = 1'b1;
        #1;
        check("t7_restart_addr", 32'(mem_addr), 32'h0000);
        check("t7_restart_rd", 32'(mem_rd_en), 1);
        for (int c = 0; c < 6; c++) step();
        check("t7_valid2", 32'(instr_valid), 1);
        check("t7_opcode2", 32'(instr_opcode), 32'h80);
        check("t7_operand2", 32'(instr_operand), 32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
